// File: rtl/search_and_add_pkg.sv
// Shared widths, FSM state codes and record layout for the search_and_add word-count front end.
package search_and_add_pkg;

   localparam int KEY_W = 128;
   localparam int VAL_W = 32;
   localparam int REC_W = 160;
   localparam int ACC_W = 65;

   typedef logic [1:0] state_t;
   localparam state_t INIT  = 2'd0;
   localparam state_t IDLE  = 2'd1;
   localparam state_t FETCH = 2'd2;
   localparam state_t MATCH = 2'd3;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] value;
   } record_t;

   // Accumulate command word: new-entry flag on top, increment in the low half.
   function automatic logic [ACC_W-1:0] make_accum(input logic is_new, input logic [VAL_W-1:0] value);
      return {is_new, 32'h0000_0000, value};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; writes while full and reads while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   assign push    = wr_en & ~full;
   assign pop     = rd_en & ~empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/search_and_add.sv
// Word-count front end: buffers key/count records, looks each key up in an associative
// table (inserting on a miss) and issues one accumulate command per processed record.
module search_and_add
   import search_and_add_pkg::*;
#(
   parameter int TABLE_DEPTH = 16,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic             ready,
   input  logic             kick,
   output logic             busy,
   input  logic [REC_W-1:0] din,
   input  logic             we,
   output logic             full,
   output logic [31:0]      accum_addr,
   output logic [ACC_W-1:0] accum_din,
   output logic             accum_we
);

   localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;

   state_t                 state;
   logic [IDX_W-1:0]       init_idx;
   logic [IDX_W:0]         next_free;
   logic [KEY_W-1:0]       keys [TABLE_DEPTH];
   logic [TABLE_DEPTH-1:0] valid;
   record_t                head;
   record_t                cur;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;
   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic                   table_full;
   logic                   insert;

   assign full       = fifo_full | ~ready;
   assign fifo_pop   = (state == FETCH) & ~fifo_empty;
   assign table_full = next_free[IDX_W];
   assign insert     = (state == MATCH) & ~hit & ~table_full;

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (we & ~full),
      .wr_data (din),
      .rd_en   (fifo_pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Parallel compare of the latched key against every valid slot; keys are unique so at most one hits.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         hit     = hit | (valid[i] && (keys[i] == cur.key));
         hit_idx = (valid[i] && (keys[i] == cur.key)) ? IDX_W'(i) : hit_idx;
      end
   end

   // Valid bits: wiped one slot per cycle during INIT, set on insertion.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= '0;
      end else if (state == INIT) begin
         valid[init_idx] <= 1'b0;
      end else if (insert) begin
         valid[next_free[IDX_W-1:0]] <= 1'b1;
      end
   end

   // Key storage.
   always_ff @(posedge clk) begin
      if (insert) keys[next_free[IDX_W-1:0]] <= cur.key;
   end

   // Control FSM and registered accumulate outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= INIT;
         init_idx   <= '0;
         ready      <= 1'b0;
         busy       <= 1'b0;
         next_free  <= '0;
         cur        <= '0;
         accum_we   <= 1'b0;
         accum_addr <= 32'h0000_0000;
         accum_din  <= '0;
      end else begin
         accum_we <= 1'b0;
         case (state)
            INIT: begin
               init_idx <= init_idx + 1'b1;
               if (init_idx == IDX_W'(TABLE_DEPTH - 1)) begin
                  ready <= 1'b1;
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (kick) begin
                  busy  <= 1'b1;
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (fifo_empty) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cur   <= head;
                  state <= MATCH;
               end
            end
            MATCH: begin
               if (hit) begin
                  accum_we   <= 1'b1;
                  accum_addr <= 32'(hit_idx);
                  accum_din  <= make_accum(1'b0, cur.value);
               end else if (!table_full) begin
                  accum_we   <= 1'b1;
                  accum_addr <= 32'(next_free[IDX_W-1:0]);
                  accum_din  <= make_accum(1'b1, cur.value);
                  next_free  <= next_free + 1'b1;
               end
               state <= FETCH;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_search_and_add.sv
// Randomised self-checking bench for search_and_add against a queue-based reference model.
module tb_search_and_add;

   localparam int TD = 16;
   localparam int FD = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         kick = 1'b0;
   logic         we = 1'b0;
   logic [159:0] din = '0;
   logic         ready;
   logic         busy;
   logic         full;
   logic [31:0]  accum_addr;
   logic [64:0]  accum_din;
   logic         accum_we;

   search_and_add #(.TABLE_DEPTH(TD), .FIFO_DEPTH(FD)) dut (
      .clk        (clk),
      .reset      (reset),
      .ready      (ready),
      .kick       (kick),
      .busy       (busy),
      .din        (din),
      .we         (we),
      .full       (full),
      .accum_addr (accum_addr),
      .accum_din  (accum_din),
      .accum_we   (accum_we)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      logic [31:0] addr;
      logic [64:0] data;
   } strobe_t;

   strobe_t       exp_q[$];
   logic [159:0]  mq[$];
   logic [127:0]  mkeys[$];
   bit            mready = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
      end
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Advance one cycle and check the strobe against the expected schedule.
   task automatic step();
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
         check_eq("accum_we", 96'(accum_we), 96'(1'b1));
         check_eq("accum_addr", 96'(accum_addr), 96'(exp_q[0].addr));
         check_eq("accum_din", 96'(accum_din), 96'(exp_q[0].data));
         void'(exp_q.pop_front());
      end else begin
         check_eq("no_strobe", 96'(accum_we), 96'(1'b0));
      end
   endtask

   task automatic do_reset();
      int r0;
      reset = 1'b1;
      mq.delete();
      exp_q.delete();
      mkeys.delete();
      mready = 1'b0;
      repeat (10) begin
         step();
         check_eq("rst_full", 96'(full), 96'(1'b1));
         check_eq("rst_ready", 96'(ready), 96'(1'b0));
         check_eq("rst_busy", 96'(busy), 96'(1'b0));
      end
      reset = 1'b0;
      r0 = cyc;
      repeat (TD + 4) begin
         step();
         check_eq("init_ready", 96'(ready), 96'(cyc >= r0 + TD));
         check_eq("init_full", 96'(full), 96'(cyc < r0 + TD));
         check_eq("init_busy", 96'(busy), 96'(1'b0));
      end
      mready = 1'b1;
   endtask

   task automatic push(input logic [127:0] k, input logic [31:0] v);
      bit exp_full;
      exp_full = !mready || (mq.size() >= FD);
      check_eq("full", 96'(full), 96'(exp_full));
      we  = 1'b1;
      din = {k, v};
      if (!exp_full) mq.push_back({k, v});
      step();
      we = 1'b0;
   endtask

   // Kick, predict every strobe with its cycle, and follow busy until it drops.
   task automatic run();
      int n;
      int k0;
      int idx;
      logic [127:0] key;
      logic [31:0]  val;
      n = mq.size();
      kick = 1'b1;
      step();
      kick = 1'b0;
      k0 = cyc;
      for (int i = 0; i < n; i++) begin
         key = mq[i][159:32];
         val = mq[i][31:0];
         idx = -1;
         for (int j = 0; j < mkeys.size(); j++) if (mkeys[j] == key) idx = j;
         if (idx >= 0) begin
            exp_q.push_back('{k0 + 2 + 2*i, 32'(idx), {1'b0, 32'h0, val}});
         end else if (mkeys.size() < TD) begin
            exp_q.push_back('{k0 + 2 + 2*i, 32'(mkeys.size()), {1'b1, 32'h0, val}});
            mkeys.push_back(key);
         end
      end
      mq.delete();
      check_eq("busy_kick", 96'(busy), 96'(1'b1));
      while (cyc < k0 + 2*n + 1) begin
         step();
         check_eq("busy", 96'(busy), 96'(cyc <= k0 + 2*n));
      end
      step();
      step();
      check_eq("exp_left", 96'(exp_q.size()), 96'(0));
   endtask

   initial begin
      logic [127:0] k1;
      logic [127:0] k2;
      logic [127:0] kd;
      int n;
      k1 = 128'hDEADBEEF_ABADCAFE_FEFEFEFE_34343434;
      k2 = 128'h00C0FFEE_01234567_89abcdef_01234567;

      do_reset();

      push(k1, 32'h5a5a5a5a);
      push(k2, 32'h89abcdef);
      run();

      push(k1, 32'h00000001);
      run();

      kd = rand_key();
      push(kd, 32'd1);
      push(kd, 32'd2);
      push(kd, 32'd3);
      run();

      for (int i = 0; i < FD + 2; i++) push(mkeys[$urandom_range(0, mkeys.size() - 1)], $urandom);
      check_eq("full_after_fill", 96'(full), 96'(1'b1));
      run();

      run();

      n = TD - mkeys.size();
      for (int i = 0; i < n; i++) push(rand_key(), $urandom);
      run();
      push(rand_key(), $urandom);
      push(k2, $urandom);
      run();

      for (int i = 0; i < 4; i++) push(rand_key(), $urandom);
      kick = 1'b1;
      step();
      kick = 1'b0;
      step();
      do_reset();

      repeat (6) begin
         n = $urandom_range(0, 6);
         for (int i = 0; i < n; i++) begin
            if (mkeys.size() > 0 && $urandom_range(0, 1) == 1) push(mkeys[$urandom_range(0, mkeys.size() - 1)], $urandom);
            else push(rand_key(), $urandom);
         end
         run();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
